// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD operand feeder and its storage.
package gcd_pkg;

  localparam int GCD_W          = 32;
  localparam int GCD_FIFO_DEPTH = 4;
  localparam int GCD_CNT_W      = 16;

  // One operand pair as presented to the GCD start method.
  typedef struct packed {
    logic [GCD_W-1:0] a;
    logic [GCD_W-1:0] b;
  } gcd_pair_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Circular buffer for operand pairs: push/pop, fill count, head read and a
// synchronous clear that also zeroes the storage.
module gcd_pair_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CNTW = AW + 1
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            push,
  input  logic [DW-1:0]   push_data,
  input  logic            pop,
  output logic [DW-1:0]   head,
  output logic [CNTW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Guard against overflow/underflow so a misbehaving caller cannot corrupt
  // the pointers.
  assign do_push = push && (count < CNTW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // Head entry reads as zero whenever nothing is buffered.
  assign head = (count == '0) ? '0 : mem[rd_ptr];

  // Storage, pointers and fill level; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNTW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/gcd_operand_feeder.sv
// Buffers operand pairs and issues them to the GCD start method when the core
// is ready, the result drain is idle this cycle, and the number of undrained
// jobs is below MAX_OUT. Zero-operand pairs are dropped and counted, since the
// subtractive core would never terminate on them.
//
// Handshakes: a pair transfers on any cycle with in_valid && in_ready;
// in_ready depends only on registered state. EN_start is a strobe that the
// GCD core takes as a start whenever it is high (it is only raised with
// RDY_start high). A result is drained on get_en && get_rdy.
module gcd_operand_feeder
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int DEPTH   = GCD_FIFO_DEPTH,
  parameter int MAX_OUT = 1,
  parameter int CW      = GCD_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_a,
  input  logic [W-1:0]               in_b,
  output logic [W-1:0]               start_a,
  output logic [W-1:0]               start_b,
  output logic                       EN_start,
  input  logic                       RDY_start,
  input  logic                       get_en,
  input  logic                       get_rdy,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CW-1:0]              issued_count,
  output logic [CW-1:0]              drop_count,
  output logic                       drop_pulse
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int OW    = $clog2(MAX_OUT + 1);

  logic [2*W-1:0] head;
  logic           accepted;
  logic           is_zero;
  logic           push;
  logic           drain;
  logic [OW-1:0]  out_cnt;

  assign in_ready = !rst && (occupancy < OCC_W'(DEPTH));
  assign accepted = in_valid && in_ready;
  assign is_zero  = (in_a == '0) || (in_b == '0);
  assign push     = accepted && !is_zero;

  // A drain with nothing outstanding is ignored so out_cnt cannot underflow.
  assign drain    = get_en && get_rdy && (out_cnt != '0);

  // Start and getResult are mutually exclusive in the wrapper, so a drain
  // request in this cycle blocks the issue.
  assign EN_start = !rst && (occupancy != '0) && RDY_start && !get_en &&
                    (out_cnt < OW'(MAX_OUT));

  assign start_a = head[2*W-1:W];
  assign start_b = head[W-1:0];

  gcd_pair_fifo #(
    .DW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clear     (rst),
    .push      (push),
    .push_data ({in_a, in_b}),
    .pop       (EN_start),
    .head      (head),
    .count     (occupancy)
  );

  // Jobs issued but not yet drained; issue and drain together cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
    end else if (EN_start && !drain) begin
      out_cnt <= out_cnt + OW'(1);
    end else if (drain && !EN_start) begin
      out_cnt <= out_cnt - OW'(1);
    end
  end

  // Issue/drop statistics; issued wraps, dropped saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_count <= '0;
      drop_count   <= '0;
      drop_pulse   <= 1'b0;
    end else begin
      if (EN_start) begin
        issued_count <= issued_count + CW'(1);
      end
      if (accepted && is_zero && (drop_count != '1)) begin
        drop_count <= drop_count + CW'(1);
      end
      drop_pulse <= accepted && is_zero;
    end
  end

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Bench for gcd_operand_feeder: directed table and hand-written sequences on a
// MAX_OUT=1 instance, queue-model checking on a MAX_OUT=2 instance.
module tb_gcd_operand_feeder;
  import gcd_pkg::*;

  logic clk;
  logic rst;

  // MAX_OUT=1 instance signals
  logic        in_valid, in_ready, en_start, rdy_start, get_en, get_rdy, drop_pulse;
  logic [31:0] in_a, in_b, start_a, start_b;
  logic [2:0]  occupancy;
  logic [15:0] issued_count, drop_count;

  // MAX_OUT=2 instance signals
  logic        m_in_valid, m_in_ready, m_en_start, m_rdy_start, m_get_en, m_get_rdy, m_drop_pulse;
  logic [31:0] m_in_a, m_in_b, m_start_a, m_start_b;
  logic [2:0]  m_occupancy;
  logic [15:0] m_issued_count, m_drop_count;

  int nvec = 0;
  int nerr = 0;

  gcd_operand_feeder #(.MAX_OUT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .start_a(start_a), .start_b(start_b),
    .EN_start(en_start), .RDY_start(rdy_start), .get_en(get_en), .get_rdy(get_rdy),
    .occupancy(occupancy), .issued_count(issued_count), .drop_count(drop_count),
    .drop_pulse(drop_pulse)
  );

  gcd_operand_feeder #(.MAX_OUT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_a(m_in_a), .in_b(m_in_b), .start_a(m_start_a), .start_b(m_start_b),
    .EN_start(m_en_start), .RDY_start(m_rdy_start), .get_en(m_get_en), .get_rdy(m_get_rdy),
    .occupancy(m_occupancy), .issued_count(m_issued_count), .drop_count(m_drop_count),
    .drop_pulse(m_drop_pulse)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic rdy, input logic ge, input logic gr);
    in_valid = v; in_a = a; in_b = b; rdy_start = rdy; get_en = ge; get_rdy = gr;
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        v;
    logic [31:0] a, b;
    logic        rdy, ge, gr;
    logic        e_en;
    logic [31:0] e_a, e_b;
    logic        e_ir;
    logic [2:0]  e_occ;
    logic [15:0] e_drop;
    logic        e_dp;
    logic [15:0] e_iss;
  } vec_t;

  vec_t tv [13];

  // ---------------- model for the MAX_OUT=2 instance ----------------
  gcd_pair_t   mq[$];
  int          m_out;
  logic [15:0] m_iss, m_drop;
  logic        m_dp;

  task automatic m_reset_model();
    mq.delete(); m_out = 0; m_iss = 0; m_drop = 0; m_dp = 0;
  endtask

  task automatic m_step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic rdy, input logic ge, input logic gr,
                        output logic acc, output logic issued);
    int          n;
    logic        e_ir, e_en, dr;
    logic [31:0] e_a, e_b;
    gcd_pair_t   p;
    m_in_valid = v; m_in_a = a; m_in_b = b; m_rdy_start = rdy; m_get_en = ge; m_get_rdy = gr;
    #1;
    n    = mq.size();
    e_ir = (n < 4);
    e_en = (n > 0) && rdy && !ge && (m_out < 2);
    e_a  = (n > 0) ? mq[0].a : 32'd0;
    e_b  = (n > 0) ? mq[0].b : 32'd0;
    chk("m_in_ready", m_in_ready, e_ir);
    chk("m_en_start", m_en_start, e_en);
    chk("m_start_a", m_start_a, e_a);
    chk("m_start_b", m_start_b, e_b);
    chk("m_occupancy", m_occupancy, n);
    chk("m_issued", m_issued_count, m_iss);
    chk("m_drops", m_drop_count, m_drop);
    chk("m_drop_pulse", m_drop_pulse, m_dp);
    acc    = v && e_ir;
    issued = e_en;
    dr     = ge && gr && (m_out > 0);
    if (e_en) begin
      void'(mq.pop_front());
      m_iss++;
      m_out++;
    end
    if (dr) m_out--;
    m_dp = 1'b0;
    if (acc) begin
      if (a == 0 || b == 0) begin
        if (m_drop != 16'hffff) m_drop++;
        m_dp = 1'b1;
      end else begin
        p.a = a; p.b = b;
        mq.push_back(p);
      end
    end
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic        acc, iss;
    int          pushed, cyc, guard;
    int          drain_at[$];
    logic [31:0] ra, rb;

    tv[0]  = '{1, 48, 18, 1, 0, 0,  0,  0,  0, 1, 0, 0, 0, 0};
    tv[1]  = '{0,  0,  0, 1, 0, 0,  1, 48, 18, 1, 1, 0, 0, 0};
    tv[2]  = '{1, 30, 12, 1, 0, 0,  0,  0,  0, 1, 0, 0, 0, 1};
    tv[3]  = '{0,  0,  0, 1, 0, 0,  0, 30, 12, 1, 1, 0, 0, 1};
    tv[4]  = '{0,  0,  0, 1, 1, 1,  0, 30, 12, 1, 1, 0, 0, 1};
    tv[5]  = '{0,  0,  0, 1, 1, 0,  0, 30, 12, 1, 1, 0, 0, 1};
    tv[6]  = '{0,  0,  0, 1, 0, 0,  1, 30, 12, 1, 1, 0, 0, 1};
    tv[7]  = '{1,  0,  7, 0, 0, 0,  0,  0,  0, 1, 0, 0, 0, 2};
    tv[8]  = '{1,  7,  0, 0, 0, 0,  0,  0,  0, 1, 0, 1, 1, 2};
    tv[9]  = '{1, 21, 14, 0, 0, 0,  0,  0,  0, 1, 0, 2, 1, 2};
    tv[10] = '{0,  0,  0, 1, 1, 1,  0, 21, 14, 1, 1, 2, 0, 2};
    tv[11] = '{0,  0,  0, 1, 0, 0,  1, 21, 14, 1, 1, 2, 0, 2};
    tv[12] = '{0,  0,  0, 0, 0, 0,  0,  0,  0, 1, 0, 2, 0, 3};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    m_in_valid = 0; m_in_a = 0; m_in_b = 0; m_rdy_start = 0; m_get_en = 0; m_get_rdy = 0;
    tick();
    tick();

    // Reset state
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_en_start", en_start, 1'b0);
    chk("rst_occupancy", occupancy, 3'd0);
    chk("rst_issued", issued_count, 16'd0);
    chk("rst_drops", drop_count, 16'd0);
    chk("rst_start_a", start_a, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // Single job, collision, zero filter
    for (int i = 0; i < 13; i++) begin
      drive(tv[i].v, tv[i].a, tv[i].b, tv[i].rdy, tv[i].ge, tv[i].gr);
      chk($sformatf("tv%0d_en", i), en_start, tv[i].e_en);
      chk($sformatf("tv%0d_a", i), start_a, tv[i].e_a);
      chk($sformatf("tv%0d_b", i), start_b, tv[i].e_b);
      chk($sformatf("tv%0d_ir", i), in_ready, tv[i].e_ir);
      chk($sformatf("tv%0d_occ", i), occupancy, tv[i].e_occ);
      chk($sformatf("tv%0d_drop", i), drop_count, tv[i].e_drop);
      chk($sformatf("tv%0d_dp", i), drop_pulse, tv[i].e_dp);
      chk($sformatf("tv%0d_iss", i), issued_count, tv[i].e_iss);
      tick();
    end

    // Clear the outstanding job from the table
    drive(0, 0, 0, 0, 1, 1);
    tick();

    // Full FIFO, held 5th pair, in-order issue
    for (int i = 0; i < 4; i++) begin
      drive(1, (i + 1) * 10, (i + 1) * 3, 0, 0, 0);
      chk("full_fill_ready", in_ready, 1'b1);
      tick();
    end
    drive(1, 50, 15, 0, 0, 0);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_occ", occupancy, 3'd4);
    tick();
    drive(1, 50, 15, 1, 0, 0);
    chk("full_first_en", en_start, 1'b1);
    chk("full_first_a", start_a, 32'd10);
    chk("full_no_passthru", in_ready, 1'b0);
    tick();
    drive(1, 50, 15, 1, 1, 1);
    chk("full_ready_back", in_ready, 1'b1);
    chk("full_occ3", occupancy, 3'd3);
    chk("full_coll_en", en_start, 1'b0);
    tick();
    for (int k = 1; k < 5; k++) begin
      drive(0, 0, 0, 1, 0, 0);
      chk("order_en", en_start, 1'b1);
      chk("order_a", start_a, (k + 1) * 10);
      chk("order_b", start_b, (k + 1) * 3);
      tick();
      drive(0, 0, 0, 1, 1, 1);
      chk("order_blocked", en_start, 1'b0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("order_issued", issued_count, 16'd8);
    chk("order_empty", occupancy, 3'd0);

    // Reset mid-stream with one job outstanding
    for (int i = 0; i < 3; i++) begin
      drive(1, 5 + i, 9, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 1, 0, 0);
    chk("mid_en", en_start, 1'b1);
    tick();
    rst = 1'b1;
    drive(1, 3, 3, 1, 0, 0);
    chk("inrst_ready", in_ready, 1'b0);
    chk("inrst_en", en_start, 1'b0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    chk("post_occ", occupancy, 3'd0);
    chk("post_en", en_start, 1'b0);
    chk("post_issued", issued_count, 16'd0);
    chk("post_drops", drop_count, 16'd0);
    chk("post_dp", drop_pulse, 1'b0);
    chk("post_ready", in_ready, 1'b1);
    chk("post_start_a", start_a, 32'd0);
    drive(1, 77, 11, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk("post_outcnt_clear", en_start, 1'b1);
    chk("post_head_a", start_a, 32'd77);
    tick();
    drive(0, 0, 0, 0, 0, 0);

    // MAX_OUT=2: stream 10 pairs, drain 3 cycles after each issue
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset_model();
    pushed = 0;
    cyc = 0;
    guard = 0;
    while (m_iss < 10 && guard < 200) begin
      logic ge;
      ge = (drain_at.size() > 0 && drain_at[0] == cyc);
      if (ge) void'(drain_at.pop_front());
      ra = $urandom_range(1, 32'hffff);
      rb = $urandom_range(1, 32'hffff);
      m_step(pushed < 10, ra, rb, 1'b1, ge, ge, acc, iss);
      if (acc) pushed++;
      if (iss) drain_at.push_back(cyc + 3);
      cyc++;
      guard++;
    end
    chk("stream_budget", (guard < 200), 1'b1);
    chk("stream_issued", m_issued_count, 16'd10);

    // Randomised traffic against the queue model
    for (int t = 0; t < 400; t++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      m_step($urandom_range(0, 9) < 7, ra, rb, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, acc, iss);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
